// File: rtl/hidden_sampler.sv
// hidden_sampler
// Bernoulli sampler for hidden-unit probabilities. Each accepted Q0.16 probability
// is either compared against a 16-bit LFSR (giving 0x0000 or 0xFFFF) or passed
// through unchanged. Results are collected into a tile buffer of H_TILE entries,
// which is presented as one parallel vector once the tile is complete.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   sample_en          1 = Bernoulli sample, 0 = pass-through (per accepted element)
//   seed, seed_load    LFSR seed and load strobe (seed 0 is replaced by 1)
//   in_valid/in_ready  input handshake; in_p probability, in_last ends tile early
//   out_valid/out_ready output tile handshake
//   out_h              H_TILE x 16 tile values, entry k at [k*16 +: 16]
//   out_bits           per-entry nonzero flags
//   out_count          entries written this tile
//   out_ones           number of nonzero entries
module hidden_sampler #(
  parameter int unsigned H_TILE   = 64,
  parameter int unsigned CNT_W    = $clog2(H_TILE + 1),
  parameter logic [15:0] LFSR_RST = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_en,
  input  logic [15:0]           seed,
  input  logic                  seed_load,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_p,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [H_TILE*16-1:0]  out_h,
  output logic [H_TILE-1:0]     out_bits,
  output logic [CNT_W-1:0]      out_count,
  output logic [CNT_W-1:0]      out_ones
);

  localparam int unsigned IdxW = (H_TILE > 1) ? $clog2(H_TILE) : 1;

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;    // write index in FILL, final count in HOLD
  logic [CNT_W-1:0]  ones_q, ones_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       buf_q [H_TILE];

  logic              accept;
  logic              tile_done;
  logic              clear_buf;
  logic [15:0]       h_new;
  logic [IdxW-1:0]   widx;

  assign in_ready = (state_q == StFill) & rst_n;
  assign accept   = in_valid & in_ready;
  assign widx     = cnt_q[IdxW-1:0];

  // Strict unsigned compare against the pre-advance LFSR state.
  assign h_new = sample_en ? ((in_p > lfsr_q) ? 16'hFFFF : 16'h0000) : in_p;

  assign tile_done = accept & (in_last | (cnt_q == CNT_W'(H_TILE - 1)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ones_d    = ones_q;
    clear_buf = 1'b0;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (h_new != 16'h0000) begin
            ones_d = ones_q + CNT_W'(1);
          end
          if (tile_done) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d   = StFill;
          cnt_d     = '0;
          ones_d    = '0;
          clear_buf = 1'b1;
        end
      end
      default: begin
        state_d = StFill;
      end
    endcase
  end

  // Seed load wins over advance; a coincident accept has already sampled lfsr_q.
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load) begin
      lfsr_d = (seed == 16'h0000) ? 16'h0001 : seed;
    end else if (accept) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFill;
      cnt_q   <= '0;
      ones_q  <= '0;
      lfsr_q  <= LFSR_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Tile buffer; cleared on reset and whenever FILL is re-entered so unused
  // tail entries of an early-terminated tile read as zero.
  always_ff @(posedge clk) begin
    for (int k = 0; k < H_TILE; k++) begin
      if (!rst_n || clear_buf) begin
        buf_q[k] <= 16'h0000;
      end else if (accept && (widx == IdxW'(k))) begin
        buf_q[k] <= h_new;
      end
    end
  end

  always_comb begin
    out_h    = '0;
    out_bits = '0;
    for (int k = 0; k < H_TILE; k++) begin
      out_h[k*16 +: 16] = buf_q[k];
      out_bits[k]       = (buf_q[k] != 16'h0000);
    end
  end

  assign out_valid = (state_q == StHold);
  assign out_count = cnt_q;
  assign out_ones  = ones_q;

endmodule

// File: tb/tb_hidden_sampler.sv
module tb_hidden_sampler;
  localparam int H  = 64;
  localparam int CW = $clog2(H + 1);

  logic            clk;
  logic            rst_n;
  logic            sample_en;
  logic [15:0]     seed;
  logic            seed_load;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_p;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [H*16-1:0] out_h;
  logic [H-1:0]    out_bits;
  logic [CW-1:0]   out_count;
  logic [CW-1:0]   out_ones;

  hidden_sampler #(.H_TILE(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en),
    .seed      (seed),
    .seed_load (seed_load),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_h     (out_h),
    .out_bits  (out_bits),
    .out_count (out_count),
    .out_ones  (out_ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_assert;
  int          n_fail;
  logic [15:0] m_lfsr;
  logic [15:0] q[$];
  logic [15:0] exp_h [H];
  int          exp_cnt;
  int          exp_ones;

  function automatic logic [15:0] adv(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One accepted element; model computes the expected entry and LFSR step.
  task automatic accept(input logic [15:0] p, input logic se, input logic last,
                        input logic sl = 1'b0, input logic [15:0] sd = 16'h0000);
    in_valid  = 1'b1;
    in_p      = p;
    sample_en = se;
    in_last   = last;
    seed_load = sl;
    seed      = sd;
    chk("in_ready_fill", in_ready, 1'b1);
    chk("out_valid_fill", out_valid, 1'b0);
    q.push_back(se ? ((p > m_lfsr) ? 16'hFFFF : 16'h0000) : p);
    @(posedge clk); #1;
    m_lfsr    = sl ? ((sd == 16'h0000) ? 16'h0001 : sd) : adv(m_lfsr);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    seed_load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_p = 16'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic seed_only(input logic [15:0] sd);
    seed_load = 1'b1;
    seed      = sd;
    @(posedge clk); #1;
    seed_load = 1'b0;
    m_lfsr    = (sd == 16'h0000) ? 16'h0001 : sd;
  endtask

  task automatic build_exp();
    exp_cnt  = q.size();
    exp_ones = 0;
    for (int k = 0; k < H; k++) begin
      exp_h[k] = (k < exp_cnt) ? q.pop_front() : 16'h0000;
      if (exp_h[k] != 16'h0000) exp_ones++;
    end
  endtask

  task automatic cmp_out(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b1);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_out_count"}, out_count, exp_cnt);
    chk({tag, "_out_ones"}, out_ones, exp_ones);
    for (int k = 0; k < H; k++) begin
      chk($sformatf("%s_h%0d", tag, k), out_h[k*16 +: 16], exp_h[k]);
      chk($sformatf("%s_bit%0d", tag, k), out_bits[k], exp_h[k] != 16'h0000);
    end
  endtask

  // Called the cycle after the final accept; optionally stalls in HOLD while
  // offering input that must not be taken.
  task automatic finish_tile(input string tag, input int hold);
    build_exp();
    cmp_out(tag);
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1;
      in_p     = 16'($urandom);
      @(posedge clk); #1;
      cmp_out({tag, "_hold"});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop_valid"}, out_valid, 1'b0);
    chk({tag, "_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    sample_en = 1'b0;
    seed      = 16'h0000;
    seed_load = 1'b0;
    in_valid  = 1'b0;
    in_p      = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b0;
    m_lfsr    = 16'hACE1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ones", out_ones, 0);
    chk("rst_out_h", out_h, '0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);

    // Pass-through full tile
    for (int k = 0; k < H; k++) accept(16'(k * 256), 1'b0, 1'b0);
    finish_tile("pass", 0);

    // Bernoulli determinism, with a 20-cycle stall in HOLD
    seed_only(16'h1234);
    for (int k = 0; k < H; k++) accept(16'h8000, 1'b1, 1'b0);
    finish_tile("bern", 20);

    // Extremes
    for (int k = 0; k < H; k++) accept(16'h0000, 1'b1, 1'b0);
    finish_tile("zero", 0);
    for (int k = 0; k < H; k++) accept(16'hFFFF, 1'b1, 1'b0);
    finish_tile("ones", 0);

    // Seed 0 maps to 1: 1 > s fails and 2 > s holds only for s == 1
    seed_only(16'h0000);
    accept(16'h0001, 1'b1, 1'b1);
    finish_tile("seed0_a", 0);
    seed_only(16'h0000);
    accept(16'h0002, 1'b1, 1'b1);
    finish_tile("seed0_b", 0);

    // Early termination, then a fresh tile
    for (int k = 0; k < 10; k++) accept(16'($urandom), 1'(k & 1), k == 9);
    finish_tile("early", 0);
    for (int k = 0; k < 5; k++) accept(16'($urandom), 1'b1, k == 4);
    finish_tile("fresh", 0);

    // Random input gaps; LFSR must hold while idle. in_last on last element.
    for (int k = 0; k < H; k++) begin
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      accept(16'($urandom), 1'($urandom_range(0, 1)), k == H - 1);
    end
    finish_tile("gaps", 20);

    // Reset mid-tile
    for (int k = 0; k < 30; k++) accept(16'($urandom), 1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    q.delete();
    m_lfsr = 16'hACE1;
    for (int k = 0; k < 12; k++) accept(16'($urandom), 1'b1, k == 11);
    finish_tile("after_rst", 0);

    // Seed load coincident with an accept
    for (int k = 0; k < 3; k++) accept(16'($urandom), 1'b1, 1'b0);
    accept(16'h8000, 1'b1, 1'b0, 1'b1, 16'h7FFF);
    accept(16'h8000, 1'b1, 1'b0);
    accept(16'h7FFF, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) accept(16'($urandom), 1'b1, k == 3);
    finish_tile("collide", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
